// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Write-side loader for the byte-wide instruction memory. A host streams bytes
// over a valid/ready handshake: a 16-bit big-endian word count, followed by
// two bytes per 16-bit instruction (high byte first). Each payload byte is
// written to instruction memory one cycle after it is accepted, at
// BASE_ADDR + byte index (wrapping modulo 2^16).
//
// Parameters:
//   BASE_ADDR  byte address of the first instruction byte written
//   MAX_WORDS  largest accepted instruction count; larger headers are rejected
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset; aborts any load in progress
//   start         one-cycle pulse, begins a load when idle (ignored otherwise)
//   inByte        stream byte
//   inValid       inByte valid
//   inReady       loader accepts inByte this cycle (decoded from state only)
//   writeAddress  instruction memory byte address
//   writeData     byte to write
//   writeEnable   write strobe, one cycle per accepted payload byte
//   busy          load in progress
//   done          load finished OK; held until the next start
//   error         header rejected (or checksum mismatch); held until next start
//
// Optional build macro:
//   INSTRUCTION_LOADER_CHECKSUM_EN  when defined, the payload is followed by a
//   one-byte XOR checksum of all payload bytes. The checksum byte is consumed
//   but never written; a mismatch ends the load with error. A zero-length load
//   still expects a checksum byte of 8'h00.
// -----------------------------------------------------------------------------
module instruction_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  inByte,
    input  logic        inValid,
    output logic        inReady,
    output logic [15:0] writeAddress,
    output logic [7:0]  writeData,
    output logic        writeEnable,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StFin,
        StErr
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StFin,
        StErr
    } state_e;
`endif

    state_e      state_q;
    logic [7:0]  count_hi_q;   // header high byte, held until the low byte arrives
    logic [16:0] total_q;      // payload length in bytes (2 * count)
    logic [16:0] index_q;      // payload bytes accepted so far
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;       // running XOR of payload bytes
`endif

    logic        accept;
    logic [15:0] hdr_count;
    logic [16:0] index_next;

    assign accept     = inValid && inReady;
    // Full count as seen while the low header byte is on the bus.
    assign hdr_count  = {count_hi_q, inByte};
    assign index_next = index_q + 17'd1;

    // Ready is a pure state decode so the host never sees a combinational
    // path from inValid back to inReady.
    always_comb begin
        inReady = 1'b0;
        case (state_q)
            StLenHi, StLenLo, StData: inReady = 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            StCsum:                   inReady = 1'b1;
`endif
            default:                  inReady = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            count_hi_q   <= 8'h00;
            total_q      <= 17'd0;
            index_q      <= 17'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
            writeAddress <= 16'h0000;
            writeData    <= 8'h00;
            writeEnable  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // Strobe is a single-cycle pulse unless DATA accepts another byte.
            writeEnable <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLenHi;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        error   <= 1'b0;
                    end
                end

                StLenHi: begin
                    if (accept) begin
                        count_hi_q <= inByte;
                        state_q    <= StLenLo;
                    end
                end

                StLenLo: begin
                    if (accept) begin
                        index_q <= 17'd0;
                        total_q <= {hdr_count, 1'b0};
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        csum_q  <= 8'h00;
`endif
                        if (hdr_count > MAX_WORDS) begin
                            state_q <= StErr;
                        end else if (hdr_count == 16'd0) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                            state_q <= StCsum;
`else
                            state_q <= StFin;
`endif
                        end else begin
                            state_q <= StData;
                        end
                    end
                end

                StData: begin
                    if (accept) begin
                        writeEnable  <= 1'b1;
                        // 16-bit add wraps past 16'hFFFF by design.
                        writeAddress <= BASE_ADDR + index_q[15:0];
                        writeData    <= inByte;
                        index_q      <= index_next;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        csum_q       <= csum_q ^ inByte;
`endif
                        // 17-bit compare so a 65536-byte payload still ends.
                        if (index_next == total_q) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                            state_q <= StCsum;
`else
                            state_q <= StFin;
`endif
                        end
                    end
                end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                StCsum: begin
                    if (accept) begin
                        state_q <= (inByte == csum_q) ? StFin : StErr;
                    end
                end
`endif

                StFin: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                StErr: begin
                    error   <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
